// File: rtl/debounce_pkg.sv
// Shared constants for the RGB mixer input debouncer.
// Holds the default qualification length, also used by the top-level encoder logic.
// Optional rise/fall edge outputs are compiled in when DEBOUNCE_EDGE_EN is defined.
package debounce_pkg;

  // Default number of consecutive clocks a new level must persist.
  localparam int DEFAULT_STABLE_CYCLES = 8;

  // Default number of debounced bits (A/B of one encoder).
  localparam int DEFAULT_CHANNELS = 2;

  // Width of the per-bit stability counter for a given qualification length.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-bit debouncer: two-flop synchroniser, stability counter, registered output.
// Latency: dout follows a steady din change STABLE_CYCLES+1 clocks after first sampling edge.
// Optional one-cycle rise/fall pulses are built only when DEBOUNCE_EDGE_EN is defined.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
`ifdef DEBOUNCE_EDGE_EN
  , output logic rise
  , output logic fall
`endif
);

  localparam int            CW   = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          accept;

  // The synchronised level has disagreed with dout long enough to be taken.
  assign differ = (s2 != dout);
  assign accept = differ && (cnt == LAST);

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Count consecutive disagreeing clocks; any agreement or an acceptance restarts from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!differ || accept) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Registered debounced level, updated only on acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout <= RESET_LEVEL;
    end else if (accept) begin
      dout <= s2;
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  // Edge pulses registered alongside dout so they coincide with its change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= accept &  s2;
      fall <= accept & ~s2;
    end
  end
`endif

endmodule

// File: rtl/debounce.sv
// Multi-channel input conditioner for the quadrature pins of the RGB mixer encoders.
// Latency: STABLE_CYCLES+1 clocks from first sampling edge, identical for every channel.
// No backpressure; optional rise/fall ports exist only when DEBOUNCE_EDGE_EN is defined.
module debounce
  import debounce_pkg::*;
#(
  parameter int   CHANNELS      = DEFAULT_CHANNELS,
  parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter logic RESET_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [CHANNELS-1:0] din,
  output logic [CHANNELS-1:0] dout
`ifdef DEBOUNCE_EDGE_EN
  , output logic [CHANNELS-1:0] rise
  , output logic [CHANNELS-1:0] fall
`endif
);

  // One fully independent debouncer per input bit.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_LEVEL   (RESET_LEVEL)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (din[i]),
      .dout    (dout[i])
`ifdef DEBOUNCE_EDGE_EN
      , .rise  (rise[i])
      , .fall  (fall[i])
`endif
    );
  end

endmodule

// File: tb/tb_debounce.sv
// Scoreboard bench for debounce: a sliding-window reference model predicts every cycle.
// Directed scenarios plus randomized dwell/reset stimulus; a negedge monitor checks outputs.
// Edge outputs are checked only when DEBOUNCE_EDGE_EN is defined.
module tb_debounce;

  localparam int   CH = 2;
  localparam int   S  = 8;
  localparam logic RL = 1'b0;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] din;
  logic [CH-1:0] dout;
`ifdef DEBOUNCE_EDGE_EN
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
`endif

  always #5 clk = ~clk;

  debounce #(
    .CHANNELS      (CH),
    .STABLE_CYCLES (S),
    .RESET_LEVEL   (RL)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (din),
    .dout    (dout)
`ifdef DEBOUNCE_EDGE_EN
    , .rise  (rise)
    , .fall  (fall)
`endif
  );

  typedef struct packed {
    logic [CH-1:0] dout;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
  } exp_t;

  exp_t          sb_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  // Reference model: per channel, the levels seen at each sampling edge.
  // A change is accepted when the S synchroniser-output levels preceding an edge
  // all disagree with the current output (synchroniser output lags the pin by two edges).
  bit            hist[CH][$];
  logic [CH-1:0] m_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_edge();
    exp_t e;
    bit   all_diff;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      if (!reset_n) begin
        hist[c].delete();
        repeat (S + 2) hist[c].push_back(RL);
        m_dout[c] = RL;
      end else begin
        hist[c].push_back(din[c]);
        void'(hist[c].pop_front());
        all_diff = 1'b1;
        for (int i = 0; i < S; i++)
          if (hist[c][i] == m_dout[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_dout[c] = ~m_dout[c];
          e.rise[c] = m_dout[c];
          e.fall[c] = ~m_dout[c];
        end
      end
    end
    e.dout = m_dout;
    sb_q.push_back(e);
  endtask

  // One clock: apply inputs, let the model see the edge, return just after the sampling negedge.
  task automatic cyc(input logic [CH-1:0] d, input logic r);
    din     = d;
    reset_n = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every expected cycle is compared against the DUT away from the active edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("dout", 32'(dout), 32'(e.dout));
`ifdef DEBOUNCE_EDGE_EN
      check("rise", 32'(rise), 32'(e.rise));
      check("fall", 32'(fall), 32'(e.fall));
`endif
    end
  end

  initial begin
    int          lat;
    int          lat1;
    int          cnt;
    int          when;
    logic        prev;
    logic        lvl;
    logic [CH-1:0] d;
    int          dwell;
    bit          do_rst;
`ifdef DEBOUNCE_EDGE_EN
    int          nrise;
    int          nfall;
`endif

    din     = '0;
    reset_n = 1'b0;

    // Reset with pins high: outputs stay at reset level, then qualify in 9 clocks.
    repeat (3) cyc(2'b11, 1'b0);
    check("rst_dout", 32'(dout), 32'(0));
`ifdef DEBOUNCE_EDGE_EN
    check("rst_edges", 32'({rise, fall}), 32'(0));
`endif
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(2'b11, 1'b1);
      if (lat < 0 && dout == 2'b11) lat = i;
    end
    check("rst_latency", 32'(lat), 32'(9));

    // Clean step on bit 0.
    repeat (20) cyc(2'b00, 1'b1);
    lat = -1;
`ifdef DEBOUNCE_EDGE_EN
    nrise = 0;
    nfall = 0;
`endif
    for (int i = 0; i < 20; i++) begin
      cyc(2'b01, 1'b1);
      if (lat < 0 && dout[0]) lat = i;
`ifdef DEBOUNCE_EDGE_EN
      nrise += int'(rise[0]);
      nfall += int'(|fall);
`endif
    end
    check("step_latency", 32'(lat), 32'(9));
`ifdef DEBOUNCE_EDGE_EN
    check("step_rise_cnt", 32'(nrise), 32'(1));
    check("step_fall_cnt", 32'(nfall), 32'(0));
`endif

    // Bounce 1,0,1,0,1 with 3-clock dwells, then hold high.
    repeat (20) cyc(2'b00, 1'b1);
    cnt  = 0;
    when = -1;
    prev = dout[0];
    for (int i = 0; i < 35; i++) begin
      lvl = (i < 15) ? (((i / 3) % 2) == 0) : 1'b1;
      cyc({1'b0, lvl}, 1'b1);
      if (dout[0] != prev) begin
        cnt++;
        when = i;
      end
      prev = dout[0];
    end
    check("bounce_transitions", 32'(cnt), 32'(1));
    check("bounce_when", 32'(when), 32'(21));

    // Threshold: 7-clock pulse rejected, 8-clock pulse accepted for exactly 8 clocks.
    cnt = 0;
`ifdef DEBOUNCE_EDGE_EN
    nrise = 0;
    nfall = 0;
`endif
    for (int i = 0; i < 75; i++) begin
      lvl = (i >= 20 && i < 27) || (i >= 47 && i < 55);
      cyc({lvl, 1'b1}, 1'b1);
      cnt += int'(dout[1]);
`ifdef DEBOUNCE_EDGE_EN
      nrise += int'(rise[1]);
      nfall += int'(fall[1]);
`endif
    end
    check("thresh_high_cycles", 32'(cnt), 32'(8));
`ifdef DEBOUNCE_EDGE_EN
    check("thresh_rise_cnt", 32'(nrise), 32'(1));
    check("thresh_fall_cnt", 32'(nfall), 32'(1));
`endif

    // Parallel change on both bits.
    repeat (20) cyc(2'b00, 1'b1);
    lat  = -1;
    lat1 = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(2'b11, 1'b1);
      if (lat < 0 && dout[0]) lat = i;
      if (lat1 < 0 && dout[1]) lat1 = i;
    end
    check("par_lat0", 32'(lat), 32'(9));
    check("par_lat1", 32'(lat1), 32'(9));

    // Reset pulse mid-count abandons the pending change.
    repeat (20) cyc(2'b00, 1'b1);
    repeat (5) cyc(2'b01, 1'b1);
    check("midrst_before", 32'(dout[0]), 32'(0));
    repeat (2) cyc(2'b01, 1'b0);
    check("midrst_during", 32'(dout[0]), 32'(0));
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      cyc(2'b01, 1'b1);
      if (lat < 0 && dout[0]) lat = i;
    end
    check("midrst_latency", 32'(lat), 32'(9));

    // Randomized levels with random dwell lengths and occasional reset pulses.
    for (int seg = 0; seg < 150; seg++) begin
      d      = CH'($urandom);
      dwell  = $urandom_range(1, 14);
      do_rst = ($urandom_range(0, 29) == 0);
      for (int j = 0; j < dwell; j++)
        cyc(d, !(do_rst && j < 2));
    end

    repeat (3) cyc(din, 1'b1);
    check("sb_drain", 32'(sb_q.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
